bcd_updown_counter: RTL and testbench

Parametrised N-digit BCD counter for the counter/stopwatch display path, clocked by the 10 Hz timebase. It is the successor to the fixed 4-digit up-only stopwatch counter and adds configurable digit count, up/down direction, parallel load, and wrap or saturate mode at the range limits. It also adds a lap-hold display register: the display freezes while counting continues. Its outputs feed the 7-segment scan/decode logic directly.

---
 rtl/bcd_updown_counter.sv | 106 ++++++++++
 tb/tb_bcd_updown_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with parallel load, wrap/saturate limits and a
// lap-hold display register that freezes the shown value while counting continues.
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk_10Hz,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic                  lap_active,
  output logic                  ovf
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [0:0] {StRun, StLap} state_e;

  state_e         state_q;
  logic [W-1:0]   count_q, count_d, display_q, step_val, clamped;
  logic           lap_q, ovf_q, ovf_d, carry, lap_rise;

  assign lap_rise = lap & ~lap_q;

  always_comb begin
    clamped  = '0;
    step_val = count_q;
    carry    = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      clamped[4*k +: 4] = (load_value[4*k +: 4] > 4'd9) ? 4'd9 : load_value[4*k +: 4];
      // carry stays set only while every digit so far was at its limit
      if (carry) begin
        if (up) begin
          if (count_q[4*k +: 4] == 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_q[4*k +: 4] == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end

    count_d = count_q;
    ovf_d   = 1'b0;
    if (load) begin
      count_d = clamped;
    end else if (en) begin
      ovf_d   = carry;
      count_d = (carry && !WRAP) ? count_q : step_val;
    end
  end

  always_ff @(posedge clk_10Hz or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      count_q   <= '0;
      display_q <= '0;
      lap_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      lap_q   <= lap;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (load) begin
        state_q   <= StRun;
        display_q <= count_d;
      end else begin
        unique case (state_q)
          StRun: begin
            if (lap_rise) begin
              state_q <= StLap;
            end else begin
              display_q <= count_d;
            end
          end
          StLap: begin
            if (lap_rise) begin
              state_q   <= StRun;
              display_q <= count_d;
            end
          end
          default: state_q <= StRun;
        endcase
      end
    end
  end

  assign count      = count_q;
  assign display    = display_q;
  assign ovf        = ovf_q;
  assign lap_active = (state_q == StLap);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: stimulus queues expected outputs tagged with a cycle index;
// a negedge monitor pops and compares them against the selected counter instance.
module tb_bcd_updown_counter;

  logic        clk_10Hz = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, up = 1'b1, load = 1'b0, lap = 1'b0;
  logic [15:0] load_value = '0;

  logic [15:0] c0, d0, c1, d1;
  logic [7:0]  c2, d2;
  logic        la0, o0, la1, o1, la2, o2;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          dut;
    logic [15:0] cnt;
    logic [15:0] disp;
    logic        la;
    logic        ovf;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_wrap (
    .clk_10Hz(clk_10Hz), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .lap(lap), .count(c0), .display(d0),
    .lap_active(la0), .ovf(o0)
  );

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0)) dut_sat (
    .clk_10Hz(clk_10Hz), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .lap(lap), .count(c1), .display(d1),
    .lap_active(la1), .ovf(o1)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_two (
    .clk_10Hz(clk_10Hz), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value[7:0]), .lap(lap), .count(c2), .display(d2),
    .lap_active(la2), .ovf(o2)
  );

  always #5 clk_10Hz = ~clk_10Hz;
  always @(posedge clk_10Hz) cyc = cyc + 1;

  function automatic logic [15:0] bcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic push(input int dut, input logic [15:0] cnt, input logic [15:0] disp,
                      input logic la, input logic ov, input int at, input string name);
    exp_t e;
    e.dut = dut; e.cnt = cnt; e.disp = disp; e.la = la; e.ovf = ov; e.cyc = at;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive(input logic e, input logic u, input logic ld, input logic [15:0] lv,
                       input logic lp);
    @(posedge clk_10Hz);
    #2;
    en = e; up = u; load = ld; load_value = lv; lap = lp;
  endtask

  // Drive one cycle of inputs and expect the given outputs after the following edge.
  task automatic tick(input logic e, input logic u, input logic ld, input logic [15:0] lv,
                      input logic lp, input int dut, input logic [15:0] cnt,
                      input logic [15:0] disp, input logic la, input logic ov,
                      input string name);
    drive(e, u, ld, lv, lp);
    push(dut, cnt, disp, la, ov, cyc + 1, name);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [15:0] ac, ad;
    logic        al, ao;
    forever begin
      @(negedge clk_10Hz);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.dut)
          0:       begin ac = c0; ad = d0; al = la0; ao = o0; end
          1:       begin ac = c1; ad = d1; al = la1; ao = o1; end
          default: begin ac = {8'h00, c2}; ad = {8'h00, d2}; al = la2; ao = o2; end
        endcase
        n_cmp++;
        if (ac !== e.cnt || ad !== e.disp || al !== e.la || ao !== e.ovf) begin
          n_err++;
          $display("FAIL %s (dut%0d cyc %0d): got count=%h display=%h lap_active=%b ovf=%b, want count=%h display=%h lap_active=%b ovf=%b",
                   e.name, e.dut, cyc, ac, ad, al, ao, e.cnt, e.disp, e.la, e.ovf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state on all instances
    @(posedge clk_10Hz);
    #2;
    for (int d = 0; d < 3; d++) push(d, 16'h0000, 16'h0000, 1'b0, 1'b0, cyc, "reset");
    @(posedge clk_10Hz);
    #2;
    reset = 1'b0;

    // Full up-count with wrap
    for (int i = 1; i <= 10000; i++)
      tick(1, 1, 0, 16'h0000, 0, 0, bcd(i % 10000), bcd(i % 10000), 0, i == 10000, "wrap_up");

    // Saturating limits
    tick(0, 1, 1, 16'h9998, 0, 1, 16'h9998, 16'h9998, 0, 0, "sat_load");
    tick(1, 1, 0, 16'h0000, 0, 1, 16'h9999, 16'h9999, 0, 0, "sat_up1");
    tick(1, 1, 0, 16'h0000, 0, 1, 16'h9999, 16'h9999, 0, 1, "sat_up2");
    tick(1, 1, 0, 16'h0000, 0, 1, 16'h9999, 16'h9999, 0, 1, "sat_up3");
    tick(0, 0, 1, 16'h0001, 0, 1, 16'h0001, 16'h0001, 0, 0, "sat_load1");
    tick(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0, "sat_dn1");
    tick(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 1, "sat_dn2");
    tick(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 1, "sat_dn3");

    // Borrow chain and load clamping
    tick(0, 0, 1, 16'h1000, 0, 0, 16'h1000, 16'h1000, 0, 0, "borrow_load");
    tick(1, 0, 0, 16'h0000, 0, 0, 16'h0999, 16'h0999, 0, 0, "borrow");
    tick(0, 0, 1, 16'h0A5F, 0, 0, 16'h0959, 16'h0959, 0, 0, "clamp");

    // Lap hold while counting continues
    tick(0, 1, 1, 16'h0042, 0, 0, 16'h0042, 16'h0042, 0, 0, "lap_load");
    tick(1, 1, 0, 16'h0000, 1, 0, 16'h0043, 16'h0042, 1, 0, "lap_enter");
    for (int i = 44; i <= 50; i++)
      tick(1, 1, 0, 16'h0000, 0, 0, bcd(i), 16'h0042, 1, 0, "lap_hold");
    tick(1, 1, 0, 16'h0000, 1, 0, 16'h0051, 16'h0051, 0, 0, "lap_exit");
    tick(0, 1, 0, 16'h0000, 0, 0, 16'h0051, 16'h0051, 0, 0, "lap_idle");

    // Load beats en and lap rise while in LAP
    tick(0, 1, 0, 16'h0000, 1, 0, 16'h0051, 16'h0051, 1, 0, "pri_enter");
    tick(1, 1, 0, 16'h0000, 0, 0, 16'h0052, 16'h0051, 1, 0, "pri_hold");
    tick(1, 1, 1, 16'h1234, 1, 0, 16'h1234, 16'h1234, 0, 0, "pri_load");
    tick(1, 1, 0, 16'h0000, 0, 0, 16'h1235, 16'h1235, 0, 0, "pri_run");
    tick(1, 1, 0, 16'h0000, 1, 0, 16'h1236, 16'h1235, 1, 0, "pri_lap");

    // Asynchronous reset mid-cycle while in LAP
    drive(1, 1, 0, 16'h0000, 0);
    @(posedge clk_10Hz);
    #2;
    reset = 1'b1;
    en = 1'b0; lap = 1'b0;
    push(0, 16'h0000, 16'h0000, 0, 0, cyc, "async_reset");
    @(posedge clk_10Hz);
    #2;
    push(0, 16'h0000, 16'h0000, 0, 0, cyc, "reset_held");
    reset = 1'b0;
    tick(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, "post_reset");

    // Two-digit wrap down and direction toggling
    tick(1, 0, 0, 16'h0000, 0, 2, 16'h0099, 16'h0099, 0, 1, "two_wrap_dn");
    tick(0, 0, 1, 16'h0050, 0, 2, 16'h0050, 16'h0050, 0, 0, "two_load");
    tick(1, 1, 0, 16'h0000, 0, 2, 16'h0051, 16'h0051, 0, 0, "toggle_up");
    tick(1, 0, 0, 16'h0000, 0, 2, 16'h0050, 16'h0050, 0, 0, "toggle_dn");
    tick(1, 1, 0, 16'h0000, 0, 2, 16'h0051, 16'h0051, 0, 0, "toggle_up");
    tick(1, 0, 0, 16'h0000, 0, 2, 16'h0050, 16'h0050, 0, 0, "toggle_dn");

    drive(0, 1, 0, 16'h0000, 0);
    repeat (3) @(posedge clk_10Hz);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
